alu_arbiter: RTL and testbench

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_arbiter.sv | 197 +++++++++++++++++++
 tb/tb_alu_arbiter.sv | 466 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// ---------------------------------------------------------------------------
// alu_arbiter
//
// Shares one combinational ALU between four requesters. A three-state FSM
// (IDLE -> EXEC -> RESP -> IDLE) grants one requester at a time, drives that
// requester's latched operands and select code to the ALU, registers the ALU
// result and holds it as a response until the consumer accepts it.
//
// Configuration macro:
//   ALU_ARB_FIXED_PRIO_EN  defined   : fixed priority, requester 0 highest,
//                                      no round-robin pointer.
//                          undefined : round-robin arbitration (default).
//
// Parameters:
//   N      ALU operand width; the ALU result is 2*N bits.
//
// Ports:
//   clk           in   1      clock, rising edge
//   reset         in   1      synchronous, active-high reset
//   req_valid     in   4      per-requester operation pending
//   req_ready     out  4      one-hot grant (IDLE only)
//   req_op1       in   4*N    packed operand1, requester i at [i*N +: N]
//   req_op2       in   4*N    packed operand2, same packing
//   req_sel       in   16     packed ALU select, requester i at [i*4 +: 4]
//   alu_operand1  out  N      operand1 to the shared ALU
//   alu_operand2  out  N      operand2 to the shared ALU
//   alu_select    out  4      select code to the shared ALU
//   alu_out       in   2*N    combinational ALU result
//   resp_valid    out  1      response available
//   resp_id       out  2      requester owning the response
//   resp_result   out  2*N    registered ALU result
//   resp_ready    in   1      consumer accepts the response
// ---------------------------------------------------------------------------
module alu_arbiter #(
  parameter int N = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [3:0]           req_valid,
  output logic [3:0]           req_ready,
  input  logic [4*N-1:0]       req_op1,
  input  logic [4*N-1:0]       req_op2,
  input  logic [15:0]          req_sel,
  output logic [N-1:0]         alu_operand1,
  output logic [N-1:0]         alu_operand2,
  output logic [3:0]           alu_select,
  input  logic [2*N-1:0]       alu_out,
  output logic                 resp_valid,
  output logic [1:0]           resp_id,
  output logic [2*N-1:0]       resp_result,
  input  logic                 resp_ready
);

  localparam int NREQ = 4;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EXEC = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  // -------------------------------------------------------------------------
  // State and datapath registers
  // -------------------------------------------------------------------------
  logic [1:0]       r_state;
  logic [N-1:0]     r_op1;
  logic [N-1:0]     r_op2;
  logic [3:0]       r_sel;
  logic [1:0]       r_id;
  logic [2*N-1:0]   r_result;
`ifndef ALU_ARB_FIXED_PRIO_EN
  logic [1:0]       r_rr_ptr;
`endif

  // -------------------------------------------------------------------------
  // Per-requester views of the packed request buses
  // -------------------------------------------------------------------------
  logic [N-1:0]     w_lane_op1 [NREQ];
  logic [N-1:0]     w_lane_op2 [NREQ];
  logic [3:0]       w_lane_sel [NREQ];

  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_lane
      assign w_lane_op1[gi] = req_op1[gi*N +: N];
      assign w_lane_op2[gi] = req_op2[gi*N +: N];
      assign w_lane_sel[gi] = req_sel[gi*4 +: 4];
    end
  endgenerate

  // -------------------------------------------------------------------------
  // Arbitration
  //
  // The search walks offsets from the highest down to the lowest so that the
  // last assignment made is the one closest to the search start; that one is
  // the winner.
  // -------------------------------------------------------------------------
  logic             w_any;
  logic [1:0]       w_winner;

  always_comb begin : p_arb
    logic [1:0] v_idx;
    w_any    = 1'b0;
    w_winner = 2'd0;
    v_idx    = 2'd0;
    for (int k = NREQ - 1; k >= 0; k--) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
      v_idx = 2'(k);
`else
      // Two-bit addition wraps 3 -> 0 naturally.
      v_idx = r_rr_ptr + 2'(k);
`endif
      if (req_valid[v_idx]) begin
        w_any    = 1'b1;
        w_winner = v_idx;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Grant generation
  //
  // Grants are only offered from IDLE. They are also suppressed while reset
  // is asserted so that nothing appears to be accepted on a reset edge.
  // -------------------------------------------------------------------------
  logic             w_idle;
  logic [3:0]       w_grant;
  logic             w_accept;

  assign w_idle = (r_state == ST_IDLE);

  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_grant
      assign w_grant[gi] = w_idle && !reset && w_any && (w_winner == 2'(gi));
    end
  endgenerate

  // The grant is derived from a valid bit, so any grant is an acceptance.
  assign w_accept  = |(w_grant & req_valid);
  assign req_ready = w_grant;

  // -------------------------------------------------------------------------
  // FSM and datapath
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= ST_IDLE;
      r_op1    <= '0;
      r_op2    <= '0;
      r_sel    <= '0;
      r_id     <= '0;
      r_result <= '0;
`ifndef ALU_ARB_FIXED_PRIO_EN
      r_rr_ptr <= '0;
`endif
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_op1    <= w_lane_op1[w_winner];
            r_op2    <= w_lane_op2[w_winner];
            r_sel    <= w_lane_sel[w_winner];
            r_id     <= w_winner;
`ifndef ALU_ARB_FIXED_PRIO_EN
            r_rr_ptr <= w_winner + 2'd1;
`endif
            r_state  <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          // The ALU has had a full cycle to settle on the latched operands.
          r_result <= alu_out;
          r_state  <= ST_RESP;
        end
        ST_RESP: begin
          if (resp_ready) begin
            r_state <= ST_IDLE;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  // The ALU sees zeros while idle so it never toggles on stale operands.
  assign alu_operand1 = w_idle ? '0 : r_op1;
  assign alu_operand2 = w_idle ? '0 : r_op2;
  assign alu_select   = w_idle ? '0 : r_sel;

  assign resp_valid   = (r_state == ST_RESP);
  assign resp_id      = r_id;
  assign resp_result  = r_result;

endmodule

// File: tb/tb_alu_arbiter.sv
// ---------------------------------------------------------------------------
// tb_alu_arbiter
//
// Self-checking bench for alu_arbiter with N=4 and an adder as the shared ALU.
// The reference model works at the transaction level: an arbitration function
// picks the winner from the pointer and valid bits, and an "outstanding
// operation" record with its age since acceptance predicts what the outputs
// must show on each cycle.
// ---------------------------------------------------------------------------
module tb_alu_arbiter;

  localparam int N = 4;

  logic              clk;
  logic              reset;
  logic [3:0]        req_valid;
  logic [3:0]        req_ready;
  logic [4*N-1:0]    req_op1;
  logic [4*N-1:0]    req_op2;
  logic [15:0]       req_sel;
  logic [N-1:0]      alu_operand1;
  logic [N-1:0]      alu_operand2;
  logic [3:0]        alu_select;
  logic [2*N-1:0]    alu_out;
  logic              resp_valid;
  logic [1:0]        resp_id;
  logic [2*N-1:0]    resp_result;
  logic              resp_ready;

  int checks;
  int errors;
  int exp_ptr;

  alu_arbiter #(.N(N)) dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_op1      (req_op1),
    .req_op2      (req_op2),
    .req_sel      (req_sel),
    .alu_operand1 (alu_operand1),
    .alu_operand2 (alu_operand2),
    .alu_select   (alu_select),
    .alu_out      (alu_out),
    .resp_valid   (resp_valid),
    .resp_id      (resp_id),
    .resp_result  (resp_result),
    .resp_ready   (resp_ready)
  );

  // Shared ALU model: plain addition, zero-extended to 2*N bits.
  assign alu_out = {{N{1'b0}}, alu_operand1} + {{N{1'b0}}, alu_operand2};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Global time limit so the bench can never hang.
  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------------
  // Helpers (stimulus and model only; no comparisons)
  // ---------------------------------------------------------------------------
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    reset      = 1'b1;
    req_valid  = 4'b0000;
    resp_ready = 1'b0;
    tick;
    tick;
    reset   = 1'b0;
    exp_ptr = 0;
  endtask

  // First requester with a valid bit, scanning upward from the pointer and
  // wrapping; fixed-priority builds always scan from requester 0.
  function automatic int arb(input logic [3:0] v, input int ptr);
    int start;
`ifdef ALU_ARB_FIXED_PRIO_EN
    start = 0;
`else
    start = ptr;
`endif
    for (int k = 0; k < 4; k++) begin
      if (v[(start + k) % 4]) return (start + k) % 4;
    end
    return -1;
  endfunction

  function automatic logic [3:0] onehot(input int g);
    logic [3:0] r;
    r = 4'b0000;
    if (g >= 0) r[g] = 1'b1;
    return r;
  endfunction

  function automatic logic [N-1:0] lane1(input int i);
    return req_op1[i*N +: N];
  endfunction

  function automatic logic [N-1:0] lane2(input int i);
    return req_op2[i*N +: N];
  endfunction

  function automatic logic [3:0] lanes(input int i);
    return req_sel[i*4 +: 4];
  endfunction

  task automatic randomize_lanes;
    req_op1 = 16'($urandom);
    req_op2 = 16'($urandom);
    req_sel = 16'($urandom);
  endtask

  // ---------------------------------------------------------------------------
  // Reset values
  // ---------------------------------------------------------------------------
  task automatic test_reset;
    reset      = 1'b1;
    req_valid  = 4'b0000;
    resp_ready = 1'b0;
    randomize_lanes();
    tick;
    tick;
    checks++;
    if (resp_valid !== 1'b0) begin errors++; $display("FAIL reset_resp_valid: got %b want 0", resp_valid); end
    checks++;
    if (resp_id !== 2'd0) begin errors++; $display("FAIL reset_resp_id: got %0d want 0", resp_id); end
    checks++;
    if (resp_result !== 8'd0) begin errors++; $display("FAIL reset_resp_result: got %0d want 0", resp_result); end
    checks++;
    if (req_ready !== 4'b0000) begin errors++; $display("FAIL reset_req_ready: got %b want 0000", req_ready); end
    checks++;
    if ({alu_operand1, alu_operand2, alu_select} !== 12'd0) begin
      errors++;
      $display("FAIL reset_alu_outputs: got %h/%h/%h want 0/0/0", alu_operand1, alu_operand2, alu_select);
    end
    reset   = 1'b0;
    exp_ptr = 0;
  endtask

  // ---------------------------------------------------------------------------
  // Single request, op1=3 op2=5 on requester 0
  // ---------------------------------------------------------------------------
  task automatic test_single;
    logic [3:0] sel;
    do_reset();
    randomize_lanes();
    sel = 4'($urandom);
    req_op1[0 +: N] = 4'd3;
    req_op2[0 +: N] = 4'd5;
    req_sel[0 +: 4] = sel;
    req_valid  = 4'b0001;
    resp_ready = 1'b1;
    #1;
    checks++;
    if (req_ready !== 4'b0001) begin errors++; $display("FAIL single_grant: got %b want 0001", req_ready); end
    tick;
    req_valid = 4'b0000;
    #1;
    checks++;
    if (resp_valid !== 1'b0 || req_ready !== 4'b0000) begin
      errors++;
      $display("FAIL single_exec: resp_valid=%b req_ready=%b want 0/0000", resp_valid, req_ready);
    end
    checks++;
    if (alu_operand1 !== 4'd3 || alu_operand2 !== 4'd5 || alu_select !== sel) begin
      errors++;
      $display("FAIL single_alu_drive: got %0d/%0d/%h want 3/5/%h", alu_operand1, alu_operand2, alu_select, sel);
    end
    tick;
    checks++;
    if (resp_valid !== 1'b1 || resp_id !== 2'd0 || resp_result !== 8'd8) begin
      errors++;
      $display("FAIL single_resp: got valid=%b id=%0d result=%0d want 1/0/8", resp_valid, resp_id, resp_result);
    end
    tick;
    checks++;
    if (resp_valid !== 1'b0) begin errors++; $display("FAIL single_handshake: resp_valid=%b want 0", resp_valid); end
    $display("txn single id=0 result=%0d", 8);
  endtask

  // ---------------------------------------------------------------------------
  // All four requesting continuously: grant order and 3-cycle spacing
  // ---------------------------------------------------------------------------
  task automatic test_round_robin;
    int g;
    logic [7:0] exp_res;
    do_reset();
    randomize_lanes();
    req_valid  = 4'b1111;
    resp_ready = 1'b1;
    for (int n = 0; n < 5; n++) begin
      #1;
      g = arb(req_valid, exp_ptr);
      exp_res = {4'b0, lane1(g)} + {4'b0, lane2(g)};
      checks++;
      if (req_ready !== onehot(g) || resp_valid !== 1'b0) begin
        errors++;
        $display("FAIL rr_grant_%0d: req_ready=%b resp_valid=%b want %b/0", n, req_ready, resp_valid, onehot(g));
      end
      tick;
      checks++;
      if (req_ready !== 4'b0000 || resp_valid !== 1'b0) begin
        errors++;
        $display("FAIL rr_exec_%0d: req_ready=%b resp_valid=%b want 0000/0", n, req_ready, resp_valid);
      end
      tick;
      checks++;
      if (resp_valid !== 1'b1 || resp_id !== 2'(g) || resp_result !== exp_res || req_ready !== 4'b0000) begin
        errors++;
        $display("FAIL rr_resp_%0d: valid=%b id=%0d result=%0d ready=%b want 1/%0d/%0d/0000",
                 n, resp_valid, resp_id, resp_result, req_ready, g, exp_res);
      end
      $display("txn rr n=%0d id=%0d result=%0d", n, g, exp_res);
      tick;
      exp_ptr = (g + 1) % 4;
    end
    req_valid = 4'b0000;
  endtask

  // ---------------------------------------------------------------------------
  // Backpressure: response held for 5 cycles with resp_ready low
  // ---------------------------------------------------------------------------
  task automatic test_backpressure;
    logic [7:0] exp_res;
    do_reset();
    randomize_lanes();
    exp_res    = {4'b0, lane1(1)} + {4'b0, lane2(1)};
    req_valid  = 4'b0010;
    resp_ready = 1'b0;
    #1;
    checks++;
    if (req_ready !== 4'b0010) begin errors++; $display("FAIL bp_grant: got %b want 0010", req_ready); end
    tick;
    req_valid = 4'b1111;   // others pending must not be granted meanwhile
    tick;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (resp_valid !== 1'b1 || resp_id !== 2'd1 || resp_result !== exp_res || req_ready !== 4'b0000) begin
        errors++;
        $display("FAIL bp_hold_%0d: valid=%b id=%0d result=%0d ready=%b want 1/1/%0d/0000",
                 i, resp_valid, resp_id, resp_result, req_ready, exp_res);
      end
      tick;
    end
    req_valid  = 4'b0000;
    resp_ready = 1'b1;
    #1;
    checks++;
    if (resp_valid !== 1'b1 || resp_result !== exp_res) begin
      errors++;
      $display("FAIL bp_before_accept: valid=%b result=%0d want 1/%0d", resp_valid, resp_result, exp_res);
    end
    tick;
    checks++;
    if (resp_valid !== 1'b0) begin errors++; $display("FAIL bp_handshake: resp_valid=%b want 0", resp_valid); end
    $display("txn bp id=1 result=%0d", exp_res);
    exp_ptr = 2;
    req_valid = 4'b1111;
    #1;
    checks++;
    if (req_ready !== onehot(arb(4'b1111, exp_ptr))) begin
      errors++;
      $display("FAIL bp_next_grant: got %b want %b", req_ready, onehot(arb(4'b1111, exp_ptr)));
    end
    req_valid = 4'b0000;
  endtask

  // ---------------------------------------------------------------------------
  // Pointer wrap: pointer at 3 with requesters 0 and 3 pending
  // ---------------------------------------------------------------------------
  task automatic test_wrap;
    int g;
    logic [7:0] exp_res;
    do_reset();
    randomize_lanes();
    resp_ready = 1'b1;
    req_valid  = 4'b0100;    // requester 2 served first moves the pointer to 3
    tick;
    req_valid = 4'b0000;
    tick;
    tick;
    exp_ptr = 3;
    req_valid = 4'b1001;
    for (int n = 0; n < 3; n++) begin
      #1;
      g = arb(req_valid, exp_ptr);
      exp_res = {4'b0, lane1(g)} + {4'b0, lane2(g)};
      checks++;
      if (req_ready !== onehot(g)) begin
        errors++;
        $display("FAIL wrap_grant_%0d: got %b want %b", n, req_ready, onehot(g));
      end
      tick;
      tick;
      checks++;
      if (resp_valid !== 1'b1 || resp_id !== 2'(g) || resp_result !== exp_res) begin
        errors++;
        $display("FAIL wrap_resp_%0d: valid=%b id=%0d result=%0d want 1/%0d/%0d",
                 n, resp_valid, resp_id, resp_result, g, exp_res);
      end
      $display("txn wrap n=%0d id=%0d result=%0d", n, g, exp_res);
      tick;
      exp_ptr = (g + 1) % 4;
    end
    req_valid = 4'b0000;
  endtask

  // ---------------------------------------------------------------------------
  // Reset during EXEC aborts silently; next request is served normally
  // ---------------------------------------------------------------------------
  task automatic test_reset_abort;
    do_reset();
    randomize_lanes();
    req_op1[0 +: N] = 4'd15;
    req_op2[0 +: N] = 4'd15;
    req_valid  = 4'b0001;
    resp_ready = 1'b1;
    tick;
    req_valid = 4'b0000;
    #1;
    checks++;
    if (alu_operand1 !== 4'd15 || alu_operand2 !== 4'd15) begin
      errors++;
      $display("FAIL abort_in_exec: operands %0d/%0d want 15/15", alu_operand1, alu_operand2);
    end
    reset = 1'b1;
    tick;
    reset = 1'b0;
    exp_ptr = 0;
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (resp_valid !== 1'b0 || resp_result !== 8'd0) begin
        errors++;
        $display("FAIL abort_no_resp_%0d: valid=%b result=%0d want 0/0", i, resp_valid, resp_result);
      end
      tick;
    end
    req_op1[2*N +: N] = 4'd1;
    req_op2[2*N +: N] = 4'd1;
    req_valid = 4'b0100;
    #1;
    checks++;
    if (req_ready !== 4'b0100) begin errors++; $display("FAIL abort_next_grant: got %b want 0100", req_ready); end
    tick;
    req_valid = 4'b0000;
    tick;
    checks++;
    if (resp_valid !== 1'b1 || resp_id !== 2'd2 || resp_result !== 8'd2) begin
      errors++;
      $display("FAIL abort_next_resp: valid=%b id=%0d result=%0d want 1/2/2", resp_valid, resp_id, resp_result);
    end
    $display("txn abort_next id=2 result=2");
    tick;
  endtask

  // ---------------------------------------------------------------------------
  // Randomized traffic: random valids (including withdrawal), operands and
  // consumer backpressure, checked every cycle against the model.
  // ---------------------------------------------------------------------------
  task automatic test_random;
    bit         busy;
    int         age;
    int         m_id;
    logic [3:0] m_op1, m_op2, m_sel;
    logic [7:0] m_res;
    int         g;
    int         errs_before;
    do_reset();
    busy = 0;
    age  = 0;
    m_id = 0;
    m_op1 = '0; m_op2 = '0; m_sel = '0; m_res = '0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      randomize_lanes();
      req_valid  = 4'($urandom);
      resp_ready = ($urandom_range(0, 2) != 0);
      #1;
      g = busy ? -1 : arb(req_valid, exp_ptr);
      errs_before = errors;
      checks++;
      if (req_ready !== onehot(g)) begin
        errors++;
        $display("FAIL rnd_ready cyc=%0d: got %b want %b", cyc, req_ready, onehot(g));
      end
      checks++;
      if (resp_valid !== (busy && age >= 1)) begin
        errors++;
        $display("FAIL rnd_resp_valid cyc=%0d: got %b want %b", cyc, resp_valid, (busy && age >= 1));
      end
      checks++;
      if (busy) begin
        if (alu_operand1 !== m_op1 || alu_operand2 !== m_op2 || alu_select !== m_sel) begin
          errors++;
          $display("FAIL rnd_alu_drive cyc=%0d: got %h/%h/%h want %h/%h/%h",
                   cyc, alu_operand1, alu_operand2, alu_select, m_op1, m_op2, m_sel);
        end
      end else if ({alu_operand1, alu_operand2, alu_select} !== 12'd0) begin
        errors++;
        $display("FAIL rnd_alu_idle cyc=%0d: got %h/%h/%h want 0/0/0", cyc, alu_operand1, alu_operand2, alu_select);
      end
      if (busy && age >= 1) begin
        checks++;
        if (resp_id !== 2'(m_id) || resp_result !== m_res) begin
          errors++;
          $display("FAIL rnd_resp cyc=%0d: id=%0d result=%0d want %0d/%0d", cyc, resp_id, resp_result, m_id, m_res);
        end
      end
      // Stop flooding the log once the model and design have diverged.
      if (errors != errs_before && errors > 20) break;

      // Advance the model across the coming edge.
      if (!busy && g >= 0) begin
        busy    = 1;
        age     = 0;
        m_id    = g;
        m_op1   = lane1(g);
        m_op2   = lane2(g);
        m_sel   = lanes(g);
        m_res   = {4'b0, m_op1} + {4'b0, m_op2};
        exp_ptr = (g + 1) % 4;
      end else if (busy && age == 0) begin
        age = 1;
      end else if (busy && resp_ready) begin
        $display("txn rnd cyc=%0d id=%0d result=%0d", cyc, m_id, m_res);
        busy = 0;
      end
      tick;
    end
    req_valid  = 4'b0000;
    resp_ready = 1'b0;
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    exp_ptr   = 0;
    reset     = 1'b1;
    req_valid = 4'b0000;
    req_op1   = '0;
    req_op2   = '0;
    req_sel   = '0;
    resp_ready = 1'b0;

    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_wrap();
    test_reset_abort();
    test_random();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
